fifo_wr_ctrl: RTL and testbench

Parametrised write-domain controller for the async FIFO. It owns the binary and Gray write pointers, accepts writes, and drives the dual-port memory write port. It computes wfull, a programmable almost-full, an overflow pulse, an occupancy level and a total-accepted-writes count from the already-synchronised Gray read pointer. It replaces the fixed 32-bit/32-deep write logic, adding width/depth generalisation, a threshold-disable mode and optional peak-level tracking.

---
 rtl/fifo_pkg.sv | 43 ++++
 rtl/fifo_gray_ptr.sv | 29 ++
 rtl/fifo_wr_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth, binary/Gray conversion and the write-side status bundle.
// Used by both the write and read controllers.
package fifo_pkg;

  // Pointer helpers work on up to 32-bit pointers; callers pass the live width.
  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  typedef struct packed {
    logic wfull;
    logic wr_almost_ful;
    logic overflow;
  } wr_status_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic ptr_max_t width_mask(input int unsigned width);
    ptr_max_t m;
    if (width >= PTR_MAX_W) m = '1;
    else                    m = (ptr_max_t'(1) << width) - ptr_max_t'(1);
    return m;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin, input int unsigned width);
    return (bin ^ (bin >> 1)) & width_mask(width);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray, input int unsigned width);
    ptr_max_t g;
    ptr_max_t bin;
    g   = gray & width_mask(width);
    bin = g;
    for (int unsigned i = 1; i < width; i++) begin
      bin = bin ^ (g >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register with increment enable and synchronous clear.
// The Gray copy is registered from the next binary value, so both change in the same cycle.
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] bin,
  output logic [PTR_WIDTH-1:0] bin_next,
  output logic [PTR_WIDTH-1:0] gray
);

  assign bin_next = bin + PTR_WIDTH'(inc);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= PTR_WIDTH'(bin2gray(ptr_max_t'(bin_next), PTR_WIDTH));
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: pointers, memory write port, full/almost-full,
// overflow, occupancy and write count. Optional peak-level tracking under FIFO_WR_PEAK_LEVEL_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  wclk,
  input  logic                  sw_rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] afull_value,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  wfull,
  output logic                  wr_almost_ful,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  fifo_write_count,
  output logic [ADDR_WIDTH:0]   wr_level
`ifdef FIFO_WR_PEAK_LEVEL_EN
  ,
  input  logic                  peak_clr,
  output logic [ADDR_WIDTH:0]   wr_peak_level
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic             accept;
  logic [PTR_W-1:0] wptr_bin;
  logic [PTR_W-1:0] wptr_bin_next;
  logic [PTR_W-1:0] rptr_bin;
  logic [PTR_W-1:0] level_next;
  wr_status_t       status_q;
  wr_status_t       status_d;

  // Registered wfull gates acceptance; the extra pointer MSB separates full from empty.
  assign accept = write_enable && !status_q.wfull;

  fifo_gray_ptr #(
    .PTR_WIDTH (PTR_W)
  ) u_wptr (
    .clk      (wclk),
    .clr      (sw_rst),
    .inc      (accept),
    .bin      (wptr_bin),
    .bin_next (wptr_bin_next),
    .gray     (wptr_gray)
  );

  assign rptr_bin   = PTR_W'(gray2bin(ptr_max_t'(rptr_gray_sync), PTR_W));
  assign level_next = wptr_bin_next - rptr_bin;

  always_comb begin
    status_d.wfull         = (level_next == PTR_W'(DEPTH));
    status_d.wr_almost_ful = (afull_value != '0) && (level_next >= {1'b0, afull_value});
    status_d.overflow      = write_enable && status_q.wfull;
  end

  always_ff @(posedge wclk) begin
    if (sw_rst) begin
      status_q         <= '0;
      mem_we           <= 1'b0;
      mem_waddr        <= '0;
      mem_wdata        <= '0;
      fifo_write_count <= '0;
      wr_level         <= '0;
    end else begin
      status_q <= status_d;
      mem_we   <= accept;
      wr_level <= level_next;
      if (accept) begin
        mem_waddr        <= wptr_bin[ADDR_WIDTH-1:0];
        mem_wdata        <= wdata;
        fifo_write_count <= fifo_write_count + CNT_WIDTH'(1);
      end
    end
  end

  assign wfull         = status_q.wfull;
  assign wr_almost_ful = status_q.wr_almost_ful;
  assign overflow      = status_q.overflow;

`ifdef FIFO_WR_PEAK_LEVEL_EN
  always_ff @(posedge wclk) begin
    if (sw_rst) begin
      wr_peak_level <= '0;
    end else if (peak_clr || (level_next > wr_peak_level)) begin
      wr_peak_level <= level_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios then random traffic, all outputs
// compared each cycle against a counter-based model (total writes minus total reads).
module tb_fifo_wr_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 6;
  localparam int DEPTH = 32;

  logic          wclk = 1'b0;
  logic          sw_rst;
  logic [DW-1:0] wdata;
  logic          write_enable;
  logic [AW-1:0] afull_value;
  logic [AW:0]   rptr_gray_sync;
  logic [AW:0]   wptr_gray;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          wfull;
  logic          wr_almost_ful;
  logic          overflow;
  logic [CW-1:0] fifo_write_count;
  logic [AW:0]   wr_level;
`ifdef FIFO_WR_PEAK_LEVEL_EN
  logic          peak_clr;
  logic [AW:0]   wr_peak_level;
`endif

  fifo_wr_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk             (wclk),
    .sw_rst           (sw_rst),
    .wdata            (wdata),
    .write_enable     (write_enable),
    .afull_value      (afull_value),
    .rptr_gray_sync   (rptr_gray_sync),
    .wptr_gray        (wptr_gray),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .wfull            (wfull),
    .wr_almost_ful    (wr_almost_ful),
    .overflow         (overflow),
    .fifo_write_count (fifo_write_count),
    .wr_level         (wr_level)
`ifdef FIFO_WR_PEAK_LEVEL_EN
    ,
    .peak_clr         (peak_clr),
    .wr_peak_level    (wr_peak_level)
`endif
  );

  always #5 wclk = ~wclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: occupancy is simply total accepted writes minus total reads presented.
  int          wr_total;
  int          rd_total;
  int          thr;
  bit          m_we, m_full, m_afull, m_ovf;
  int          m_waddr;
  logic [DW-1:0] m_wdata;
  int          m_count;
  int          m_level;
  int          m_peak;
  bit          pclr;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [DW-1:0] d);
    bit acc;
    int lvl;
    if (rst) begin
      wr_total = 0; m_we = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      m_waddr = 0; m_wdata = '0; m_count = 0; m_level = 0; m_peak = 0;
      return;
    end
    acc   = we && !m_full;
    m_ovf = we && m_full;
    m_we  = acc;
    if (acc) begin
      m_waddr = wr_total % DEPTH;
      m_wdata = d;
      wr_total++;
      m_count = (m_count + 1) % (1 << CW);
    end
    lvl     = wr_total - rd_total;
    m_level = lvl;
    m_full  = (lvl == DEPTH);
    m_afull = (thr != 0) && (lvl >= thr);
    if (pclr || lvl > m_peak) m_peak = lvl;
  endtask

  task automatic compare_all();
    check("wptr_gray", 64'(wptr_gray), 64'(gray_of(wr_total)));
    check("mem_we", 64'(mem_we), 64'(m_we));
    check("mem_waddr", 64'(mem_waddr), 64'(m_waddr));
    check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check("wfull", 64'(wfull), 64'(m_full));
    check("wr_almost_ful", 64'(wr_almost_ful), 64'(m_afull));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("fifo_write_count", 64'(fifo_write_count), 64'(m_count));
    check("wr_level", 64'(wr_level), 64'(m_level));
`ifdef FIFO_WR_PEAK_LEVEL_EN
    check("wr_peak_level", 64'(wr_peak_level), 64'(m_peak));
`endif
  endtask

  // Called at a negedge: drive, clock, update model, then sample at the following negedge.
  task automatic step(input bit rst, input bit we, input logic [DW-1:0] d);
    sw_rst         = rst;
    write_enable   = we;
    wdata          = d;
    afull_value    = AW'(thr);
    rptr_gray_sync = gray_of(rd_total);
`ifdef FIFO_WR_PEAK_LEVEL_EN
    peak_clr       = pclr;
`endif
    @(posedge wclk);
    model_edge(rst, we, d);
    @(negedge wclk);
    compare_all();
  endtask

  task automatic do_reset();
    rd_total = 0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, $urandom);
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, $urandom);
  endtask

  initial begin
    thr = 28; pclr = 0; rd_total = 0; wr_total = 0;
    do_reset();
    check("reset_level", 64'(wr_level), 64'd0);

    // Fill with almost-full threshold 28, then three dropped writes.
    writes(27);
    check("afull_before_28", 64'(wr_almost_ful), 64'd0);
    writes(1);
    check("afull_after_28", 64'(wr_almost_ful), 64'd1);
    writes(3);
    check("not_full_31", 64'(wfull), 64'd0);
    writes(1);
    check("full_after_32", 64'(wfull), 64'd1);
    check("count_32", 64'(fifo_write_count), 64'd32);
    writes(3);
    check("ovf_held", 64'(overflow), 64'd1);
    check("count_still_32", 64'(fifo_write_count), 64'd32);
    step(1'b0, 1'b0, '0);
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Read side advances by 4: level 28, then 4 writes wrap the address.
    rd_total = 4;
    step(1'b0, 1'b0, '0);
    check("level_28", 64'(wr_level), 64'd28);
    check("not_full_after_read", 64'(wfull), 64'd0);
    writes(4);
    check("wrap_addr_3", 64'(mem_waddr), 64'd3);
    check("gray_36", 64'(wptr_gray), 64'(gray_of(36)));

    // Threshold disabled: no almost-full even at full.
    thr = 0;
    do_reset();
    writes(33);
    check("afull_disabled", 64'(wr_almost_ful), 64'd0);

    // Reset wins over a simultaneous write at level 10.
    do_reset();
    writes(10);
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    check("rst_prio_we", 64'(mem_we), 64'd0);
    check("rst_prio_level", 64'(wr_level), 64'd0);
    check("rst_prio_gray", 64'(wptr_gray), 64'd0);

`ifdef FIFO_WR_PEAK_LEVEL_EN
    rd_total = 0;
    step(1'b0, 1'b0, '0);
    writes(20);
    for (int i = 0; i < 15; i++) begin
      rd_total++;
      step(1'b0, 1'b0, '0);
    end
    check("peak_20", 64'(wr_peak_level), 64'd20);
    pclr = 1;
    step(1'b0, 1'b0, '0);
    pclr = 0;
    check("peak_clr_5", 64'(wr_peak_level), 64'd5);
`endif

    // Random traffic with read advances, threshold changes and occasional resets.
    thr = 20;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        if (rd_total < wr_total && $urandom_range(2) == 0) rd_total++;
        if ($urandom_range(49) == 0) thr = $urandom_range(DEPTH-1);
        pclr = ($urandom_range(63) == 0);
        step(1'b0, ($urandom_range(9) < 7), $urandom);
      end
    end
    pclr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
